fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encodings,
// PC step sizes and the compressed-halfword test.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP_HALF = 32'd2;
    localparam logic [31:0] PC_STEP_WORD = 32'd4;

    // Anything other than 2'b11 in the low bits is a 16-bit instruction.
    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: pulls 32-bit words from the icache, splits them into
// 16/32-bit instructions and issues one instruction per inst_req pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_RUN  | idle: issue a buffered compressed half or launch a fetch
// ST_WAIT | fetch outstanding, response consumed to issue/buffer
// ST_DROP | fetch outstanding after a redirect, response is discarded
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_data,
    output logic        inst_req,
    output logic [31:0] inst,
    output logic [31:0] addr
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] hi_half_q, hi_half_d;
    logic        hi_valid_q, hi_valid_d;
    logic        ic_req_valid_q, ic_req_valid_d;
    logic [31:0] ic_req_addr_q, ic_req_addr_d;
    logic        inst_req_q, inst_req_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_base;

    assign word_base = {pc_q[31:2], 2'b00};

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hi_half_d      = hi_half_q;
        hi_valid_d     = hi_valid_q;
        ic_req_valid_d = ic_req_valid_q;
        ic_req_addr_d  = ic_req_addr_q;
        inst_req_d     = inst_req_q;
        inst_d         = inst_q;
        addr_d         = addr_q;

        if (rdy_in) begin
            inst_req_d = 1'b0;
            if (redirect_valid) begin
                pc_d = redirect_addr;
                if (state_q != ST_DROP) begin
                    hi_valid_d = 1'b0;
                end
                // A response landing with the redirect is already stale.
                if (state_q != ST_RUN) begin
                    if (ic_resp_valid) begin
                        state_d        = ST_RUN;
                        ic_req_valid_d = 1'b0;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (!stall_in) begin
                            if (pc_q[1] && hi_valid_q && is_compressed(hi_half_q)) begin
                                inst_req_d = 1'b1;
                                inst_d     = {16'h0, hi_half_q};
                                addr_d     = pc_q;
                                pc_d       = pc_q + PC_STEP_HALF;
                                hi_valid_d = 1'b0;
                            end else begin
                                ic_req_valid_d = 1'b1;
                                ic_req_addr_d  = (pc_q[1] && hi_valid_q) ? word_base + PC_STEP_WORD
                                                                         : word_base;
                                state_d        = ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (ic_resp_valid && !stall_in) begin
                            state_d        = ST_RUN;
                            ic_req_valid_d = 1'b0;
                            if (!pc_q[1]) begin
                                inst_req_d = 1'b1;
                                addr_d     = pc_q;
                                if (is_compressed(ic_resp_data[15:0])) begin
                                    inst_d     = {16'h0, ic_resp_data[15:0]};
                                    pc_d       = pc_q + PC_STEP_HALF;
                                    hi_half_d  = ic_resp_data[31:16];
                                    hi_valid_d = 1'b1;
                                end else begin
                                    inst_d     = ic_resp_data;
                                    pc_d       = pc_q + PC_STEP_WORD;
                                    hi_valid_d = 1'b0;
                                end
                            end else if (hi_valid_q) begin
                                inst_req_d = 1'b1;
                                addr_d     = pc_q;
                                inst_d     = {ic_resp_data[15:0], hi_half_q};
                                pc_d       = pc_q + PC_STEP_WORD;
                                hi_half_d  = ic_resp_data[31:16];
                                hi_valid_d = 1'b1;
                            end else begin
                                hi_half_d  = ic_resp_data[31:16];
                                hi_valid_d = 1'b1;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (ic_resp_valid) begin
                            state_d        = ST_RUN;
                            ic_req_valid_d = 1'b0;
                        end
                    end
                    default: state_d = ST_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            hi_half_q      <= 16'h0;
            hi_valid_q     <= 1'b0;
            ic_req_valid_q <= 1'b0;
            ic_req_addr_q  <= 32'h0;
            inst_req_q     <= 1'b0;
            inst_q         <= 32'h0;
            addr_q         <= 32'h0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            hi_half_q      <= hi_half_d;
            hi_valid_q     <= hi_valid_d;
            ic_req_valid_q <= ic_req_valid_d;
            ic_req_addr_q  <= ic_req_addr_d;
            inst_req_q     <= inst_req_d;
            inst_q         <= inst_d;
            addr_q         <= addr_d;
        end
    end

    // A pulse held across a freeze is shown once rdy_in returns.
    assign inst_req     = inst_req_q & rdy_in;
    assign inst         = inst_q;
    assign addr         = addr_q;
    assign ic_req_valid = ic_req_valid_q;
    assign ic_req_addr  = ic_req_addr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: icache responder, instruction-stream model
// derived from memory contents, and directed scenarios.
module tb_fetch_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        ic_resp_valid = 1'b0;
    logic [31:0] ic_resp_data = 32'h0;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        inst_req;
    logic [31:0] inst;
    logic [31:0] addr;

    fetch_sequencer #(.RESET_PC(32'h0)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_data   (ic_resp_data),
        .inst_req       (inst_req),
        .inst           (inst),
        .addr           (addr)
    );

    always #5 clk_in = ~clk_in;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem [256];
    logic [31:0] mpc = 32'h0;
    int          inst_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] inst_log [16];
    logic [31:0] addr_log [16];
    logic [31:0] req_log [16];
    bit          resp_en = 1'b1;
    bit          prev_valid = 1'b0;
    logic [15:0] m_h;
    logic [31:0] m_exp;
    logic [31:0] m_nxt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Model: the issued stream is the program laid out in memory from the
    // current PC, split by the compressed rule; redirects reload the PC.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            mpc           = 32'h0;
            inst_cnt      = 0;
            req_cnt       = 0;
            prev_valid    = 1'b0;
            ic_resp_valid = 1'b0;
        end else begin
            if (redirect_valid) mpc = redirect_addr;
            if (inst_req) begin
                m_h = hw(mpc);
                if (m_h[1:0] != 2'b11) begin
                    m_exp = {16'h0, m_h};
                    m_nxt = mpc + 32'd2;
                end else begin
                    m_exp = {hw(mpc + 32'd2), m_h};
                    m_nxt = mpc + 32'd4;
                end
                check("model_inst", inst, m_exp);
                check("model_addr", addr, mpc);
                if (inst_cnt < 16) begin
                    inst_log[inst_cnt] = inst;
                    addr_log[inst_cnt] = addr;
                end
                inst_cnt++;
                mpc = m_nxt;
            end
            // icache: respond one cycle after the request, hold until taken
            if (ic_req_valid && !prev_valid) begin
                if (req_cnt < 16) req_log[req_cnt] = ic_req_addr;
                req_cnt++;
                check("req_align", {30'h0, ic_req_addr[1:0]}, 32'h0);
            end
            prev_valid = ic_req_valid;
            if (ic_resp_valid && !ic_req_valid) begin
                ic_resp_valid = 1'b0;
            end else if (!ic_resp_valid && ic_req_valid && resp_en) begin
                ic_resp_valid = 1'b1;
                ic_resp_data  = mem[ic_req_addr[9:2]];
            end
        end
    end

    task automatic start(input bit en);
        @(posedge clk_in); #2;
        rst_in   = 1'b0;
        stall_in = 1'b0;
        rdy_in   = 1'b1;
        resp_en  = en;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk_in);
    endtask

    task automatic release_rst();
        #2 rst_in = 1'b1;
    endtask

    task automatic wait_inst(input int n, input string name);
        int k = 0;
        while (inst_cnt < n && k < 200) begin @(negedge clk_in); k++; end
        check(name, (inst_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_req(input int n, input string name);
        int k = 0;
        while (req_cnt < n && k < 200) begin @(negedge clk_in); k++; end
        check(name, (req_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        @(negedge clk_in);
        while (!ic_req_valid && k < 50) begin @(negedge clk_in); k++; end
        check(name, {31'h0, ic_req_valid}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] a);
        @(posedge clk_in); #2;
        redirect_valid = 1'b1;
        redirect_addr  = a;
        @(posedge clk_in); #2;
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        // reset values
        #12;
        check("rst_req_valid", {31'h0, ic_req_valid}, 32'h0);
        check("rst_req_addr", ic_req_addr, 32'h0);
        check("rst_inst_req", {31'h0, inst_req}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_addr", addr, 32'h0);

        // 32-bit word at 0
        start(1'b1);
        mem[0] = 32'h00000513; mem[1] = 32'h00000013;
        release_rst();
        wait_inst(1, "t1_inst_timeout");
        check("t1_inst", inst_log[0], 32'h00000513);
        check("t1_addr", addr_log[0], 32'h0);
        wait_req(2, "t1_req_timeout");
        check("t1_req0", req_log[0], 32'h0);
        check("t1_req1", req_log[1], 32'h4);

        // two compressed halves in one word
        start(1'b1);
        mem[0] = 32'h45014501;
        release_rst();
        wait_inst(2, "t2_inst_timeout");
        check("t2_inst0", inst_log[0], 32'h00004501);
        check("t2_addr0", addr_log[0], 32'h0);
        check("t2_inst1", inst_log[1], 32'h00004501);
        check("t2_addr1", addr_log[1], 32'h2);
        wait_req(2, "t2_req_timeout");
        check("t2_req1", req_log[1], 32'h4);

        // 32-bit instruction split across words
        start(1'b1);
        mem[0] = 32'h05134501; mem[1] = 32'h00000000;
        release_rst();
        wait_inst(3, "t3_inst_timeout");
        check("t3_inst1", inst_log[1], 32'h00000513);
        check("t3_addr1", addr_log[1], 32'h2);
        check("t3_inst2", inst_log[2], 32'h0);
        check("t3_addr2", addr_log[2], 32'h6);
        wait_req(2, "t3_req_timeout");
        check("t3_req1", req_log[1], 32'h4);

        // redirect while waiting: stale response dropped
        start(1'b0);
        mem[0] = 32'h00000013; mem[64] = 32'h00134501; mem[65] = 32'h0;
        release_rst();
        wait_valid("t4_req_timeout");
        redirect(32'h00000102);
        resp_en = 1'b1;
        wait_inst(1, "t4_inst_timeout");
        wait_req(3, "t4_req3_timeout");
        check("t4_req1", req_log[1], 32'h100);
        check("t4_req2", req_log[2], 32'h104);
        check("t4_inst0", inst_log[0], 32'h00000013);
        check("t4_addr0", addr_log[0], 32'h102);

        // stall with a buffered compressed half
        start(1'b1);
        mem[0] = 32'h45014501;
        release_rst();
        begin
            int k = 0;
            @(negedge clk_in);
            while (!inst_req && k < 50) begin @(negedge clk_in); k++; end
            check("t5_first_timeout", {31'h0, inst_req}, 32'd1);
        end
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("t5_stalled_inst_req", {31'h0, inst_req}, 32'h0);
            check("t5_stalled_fetch", {31'h0, ic_req_valid}, 32'h0);
        end
        stall_in = 1'b0;
        @(negedge clk_in);
        check("t5_release_req", {31'h0, inst_req}, 32'h1);
        check("t5_release_inst", inst, 32'h00004501);
        check("t5_release_addr", addr, 32'h2);
        @(negedge clk_in);
        check("t5_single_pulse", {31'h0, inst_req}, 32'h0);

        // rdy low mid-wait freezes everything
        start(1'b0);
        mem[0] = 32'h00000513;
        release_rst();
        wait_valid("t6_req_timeout");
        rdy_in  = 1'b0;
        resp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("t6_frozen_valid", {31'h0, ic_req_valid}, 32'h1);
            check("t6_frozen_addr", ic_req_addr, 32'h0);
            check("t6_frozen_inst_req", {31'h0, inst_req}, 32'h0);
        end
        rdy_in = 1'b1;
        wait_inst(1, "t6_inst_timeout");
        check("t6_inst", inst_log[0], 32'h00000513);
        check("t6_addr", addr_log[0], 32'h0);
        wait_req(2, "t6_req_timeout2");
        check("t6_req1", req_log[1], 32'h4);

        // stall in WAIT holds the response
        start(1'b0);
        mem[0] = 32'h00000513;
        release_rst();
        wait_valid("t7_req_timeout");
        stall_in = 1'b1;
        resp_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("t7_hold_valid", {31'h0, ic_req_valid}, 32'h1);
            check("t7_hold_inst_req", {31'h0, inst_req}, 32'h0);
        end
        stall_in = 1'b0;
        wait_inst(1, "t7_inst_timeout");
        check("t7_inst", inst_log[0], 32'h00000513);

        // reset mid-wait abandons the request
        start(1'b0);
        mem[0] = 32'h00000513;
        release_rst();
        wait_valid("t8_req_timeout");
        @(posedge clk_in); #2;
        rst_in = 1'b0;
        #1;
        check("t8_rst_valid", {31'h0, ic_req_valid}, 32'h0);
        check("t8_rst_addr", ic_req_addr, 32'h0);
        repeat (2) @(posedge clk_in);
        resp_en = 1'b1;
        release_rst();
        wait_inst(1, "t8_inst_timeout");
        check("t8_inst", inst_log[0], 32'h00000513);
        check("t8_addr", addr_log[0], 32'h0);

        // PC wraps across the top of the address space
        start(1'b0);
        mem[255] = 32'h00130000; mem[0] = 32'h0;
        release_rst();
        wait_valid("t9_req_timeout");
        redirect(32'hFFFFFFFE);
        resp_en = 1'b1;
        wait_inst(2, "t9_inst_timeout");
        wait_req(3, "t9_req3_timeout");
        check("t9_req1", req_log[1], 32'hFFFFFFFC);
        check("t9_req2", req_log[2], 32'h0);
        check("t9_inst0", inst_log[0], 32'h00000013);
        check("t9_addr0", addr_log[0], 32'hFFFFFFFE);
        check("t9_addr1", addr_log[1], 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
